// File: rtl/softmax_div_feeder.sv
// Softmax divider feeder: buffers one vector of exp values with their sum, streams
// x*2^16 / sum through a pipelined divider and re-tags the quotients in input order.
module softmax_div_feeder #(
  parameter int N_MAX   = 16,
  parameter int DIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic        div_en,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_quotient,
  input  logic        div_by_0,
  output logic        m_valid,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        m_dz
);

  localparam int AW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int CW = $clog2(N_MAX + 1);

  typedef enum logic [1:0] {LOAD, DIVIDE, DRAIN} state_t;

  state_t            state;
  logic [15:0]       buf_mem [N_MAX];
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     n_len;
  logic [CW-1:0]     idx;
  logic [31:0]       sum;
  logic [DIV_LAT-1:0] tag_v;
  logic [DIV_LAT-1:0] tag_l;

  logic              accept;
  logic [31:0]       sum_next;
  logic              tag_in_v;
  logic              tag_in_l;
  logic [AW-1:0]     rd_idx;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    accept   = s_valid & s_ready;
    sum_next = sum + {16'h0000, s_data};
    tag_in_v = (state == DIVIDE);
    tag_in_l = (state == DIVIDE) && (idx == n_len - 1'b1);
    rd_idx   = AW'(idx + 1'b1);
  end

  // NOTE: the element buffer has no reset; cnt alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[cnt[AW-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      cnt     <= '0;
      n_len   <= '0;
      idx     <= '0;
      sum     <= '0;
      s_ready <= 1'b1;
      div_en  <= 1'b0;
      div_a   <= '0;
      div_b   <= '0;
      tag_v   <= '0;
      tag_l   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_dz    <= 1'b0;
    end else begin
      // Tags move in lock-step with the divider so stage DIV_LAT-1 matches div_quotient.
      if (div_en) begin
        tag_v <= (tag_v << 1) | DIV_LAT'(tag_in_v);
        tag_l <= (tag_l << 1) | DIV_LAT'(tag_in_l);
      end

      m_valid <= div_en & tag_v[DIV_LAT-1];
      m_last  <= tag_l[DIV_LAT-1];
      m_dz    <= div_by_0;
      m_data  <= div_by_0 ? '0 : div_quotient;

      case (state)
        LOAD: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            sum <= sum_next;
            if (s_last || (cnt == CW'(N_MAX - 1))) begin
              n_len   <= cnt + 1'b1;
              idx     <= '0;
              state   <= DIVIDE;
              s_ready <= 1'b0;
              div_en  <= 1'b1;
              // Element 0 is still being written when the vector is one element long.
              div_a   <= {(cnt == '0) ? s_data : buf_mem[0], 16'h0000};
              div_b   <= sum_next;
            end
          end
        end

        DIVIDE: begin
          if (idx == n_len - 1'b1) begin
            state <= DRAIN;
          end else begin
            idx   <= idx + 1'b1;
            div_a <= {buf_mem[rd_idx], 16'h0000};
          end
        end

        DRAIN: begin
          if (tag_l[DIV_LAT-1]) begin
            state   <= LOAD;
            s_ready <= 1'b1;
            div_en  <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            idx     <= '0;
          end
        end

        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_div_feeder.sv
// Bench for softmax_div_feeder: behavioural divider, table vectors, corner sequences
// and random vectors checked against a vector-level reference model.
module tb_softmax_div_feeder;
  localparam int N_MAX   = 16;
  localparam int DIV_LAT = 4;
  localparam int HIST    = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        div_en;
  logic [31:0] div_a, div_b, div_quotient;
  logic        div_by_0;
  logic        m_valid, m_last, m_dz;
  logic [31:0] m_data;

  softmax_div_feeder #(.N_MAX(N_MAX), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .div_en(div_en), .div_a(div_a), .div_b(div_b),
    .div_quotient(div_quotient), .div_by_0(div_by_0),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_dz(m_dz)
  );

  always #5 clk = ~clk;

  // Behavioural pipelined divider: DIV_LAT en-gated stages.
  logic [31:0] pa [DIV_LAT];
  logic [31:0] pb [DIV_LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIV_LAT; i++) begin pa[i] <= '0; pb[i] <= '0; end
    end else if (div_en) begin
      pa[0] <= div_a;
      pb[0] <= div_b;
      for (int i = 1; i < DIV_LAT; i++) begin pa[i] <= pa[i-1]; pb[i] <= pb[i-1]; end
    end
  end
  assign div_by_0     = (pb[DIV_LAT-1] == 32'h0);
  assign div_quotient = div_by_0 ? 32'hFFFF_FFFF : pa[DIV_LAT-1] / pb[DIV_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [31:0] data; logic last; logic dz; int cyc;} res_t;
  typedef struct {int t; int n;} win_t;
  res_t        exp_q[$];
  res_t        out_q[$];
  win_t        win_q[$];
  logic [15:0] cur_v[$];
  logic        rdy_hist [HIST];

  always @(negedge clk) begin
    if (cyc < HIST) rdy_hist[cyc] = s_ready;
    if (m_valid) out_q.push_back(res_t'{m_data, m_last, m_dz, cyc});
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Reference model: a vector closes on s_last or on its N_MAX-th element; every element
  // yields x*2^16/sum (0 with dz when the sum is 0), element k of a vector closed at
  // cycle t arriving at t+1+k+DIV_LAT+1.
  task automatic model_accept(input logic [15:0] d, input logic l, input int t);
    longint s;
    cur_v.push_back(d);
    if (l || cur_v.size() == N_MAX) begin
      s = 0;
      foreach (cur_v[i]) s += longint'(cur_v[i]);
      for (int k = 0; k < cur_v.size(); k++) begin
        res_t r;
        r.dz   = (s == 0);
        r.data = (s == 0) ? 32'h0 : 32'((longint'(cur_v[k]) * 65536) / s);
        r.last = (k == cur_v.size() - 1);
        r.cyc  = t + 1 + k + DIV_LAT + 1;
        exp_q.push_back(r);
      end
      win_q.push_back(win_t'{t, cur_v.size()});
      cur_v.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l, output int t);
    logic acc;
    acc = 1'b0;
    t = cyc;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int w = 0; w < 400; w++) begin
      if (s_ready) begin acc = 1'b1; t = cyc; end
      @(negedge clk);
      if (acc) break;
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (!acc) bound_fail("accept");
    else model_accept(d, l, t);
  endtask

  task automatic wait_outputs(input int k);
    for (int w = 0; w < 3000; w++) begin
      if (out_q.size() >= k) return;
      @(negedge clk);
    end
    bound_fail("outputs");
  endtask

  task automatic check_vs_model();
    res_t e, a;
    int   bad;
    wait_outputs(exp_q.size());
    while (exp_q.size() > 0 && out_q.size() > 0) begin
      e = exp_q.pop_front();
      a = out_q.pop_front();
      check("model_data", a.data, e.data);
      check("model_last", a.last, e.last);
      check("model_dz",   a.dz,   e.dz);
      check("model_cycle", a.cyc, e.cyc);
    end
    exp_q.delete();
    while (win_q.size() > 0) begin
      win_t w;
      w = win_q.pop_front();
      bad = 0;
      for (int c = w.t + 1; c <= w.t + w.n + 4; c++)
        if (c < HIST && rdy_hist[c] !== 1'b0) bad++;
      check("ready_low_while_busy", bad, 0);
      if (w.t + w.n + 5 < HIST) check("ready_at_last_out", rdy_hist[w.t + w.n + 5], 1'b1);
    end
  endtask

  typedef struct {int n; logic [15:0] x[4]; logic [31:0] q[4]; logic dz;} vec_t;
  vec_t tbl[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t16, t17, n, mode, bad;
    logic [15:0] d;

    tbl[0].n = 1; tbl[0].dz = 0;
    tbl[0].x = '{16'h1234, 16'h0, 16'h0, 16'h0};
    tbl[0].q = '{32'h0001_0000, 32'h0, 32'h0, 32'h0};
    tbl[1].n = 4; tbl[1].dz = 0;
    tbl[1].x = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    tbl[1].q = '{32'h0000_4000, 32'h0000_4000, 32'h0000_4000, 32'h0000_4000};
    tbl[2].n = 2; tbl[2].dz = 0;
    tbl[2].x = '{16'h0001, 16'h0003, 16'h0, 16'h0};
    tbl[2].q = '{32'h0000_4000, 32'h0000_C000, 32'h0, 32'h0};
    tbl[3].n = 2; tbl[3].dz = 1;
    tbl[3].x = '{16'h0000, 16'h0000, 16'h0, 16'h0};
    tbl[3].q = '{32'h0, 32'h0, 32'h0, 32'h0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_div_en",  div_en, 1'b0);
    check("rst_div_a",   div_a, 32'h0);
    check("rst_div_b",   div_b, 32'h0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data",  m_data, 32'h0);
    check("rst_m_last",  m_last, 1'b0);
    check("rst_m_dz",    m_dz, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", s_ready, 1'b1);
    out_q.delete();

    // Table-driven vectors
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < tbl[v].n; i++) send_beat(tbl[v].x[i], i == tbl[v].n - 1, t);
      wait_outputs(tbl[v].n);
      if (out_q.size() > 0) check($sformatf("tbl%0d_first_latency", v), out_q[0].cyc - t, 6);
      for (int k = 0; k < tbl[v].n; k++) begin
        if (k < out_q.size()) begin
          check($sformatf("tbl%0d_data%0d", v, k), out_q[k].data, tbl[v].q[k]);
          check($sformatf("tbl%0d_last%0d", v, k), out_q[k].last, k == tbl[v].n - 1);
          check($sformatf("tbl%0d_dz%0d", v, k),   out_q[k].dz, tbl[v].dz);
        end
      end
      check_vs_model();
      idle(2);
    end

    // Forced last: 17 beats, no s_last
    t16 = 0; t17 = 0;
    for (int i = 0; i < 17; i++) begin
      send_beat(16'h0010, 1'b0, t);
      if (i == 15) t16 = t;
      if (i == 16) t17 = t;
    end
    wait_outputs(16);
    if (out_q.size() >= 16) begin
      bad = 0;
      for (int k = 0; k < 16; k++) if (out_q[k].data !== 32'h0000_1000) bad++;
      check("forced_data", bad, 0);
      check("forced_last_flag", out_q[15].last, 1'b1);
      check("forced_mid_last", out_q[14].last, 1'b0);
    end
    check("beat17_accept_cycle", t17, t16 + 16 + DIV_LAT + 1);
    check_vs_model();
    send_beat(16'h0030, 1'b1, t);
    wait_outputs(2);
    if (out_q.size() >= 2) begin
      check("carry_data0", out_q[0].data, 32'h0000_4000);
      check("carry_data1", out_q[1].data, 32'h0000_C000);
    end
    check_vs_model();
    idle(2);

    // Reset during DRAIN
    send_beat(16'd5, 1'b0, t);
    send_beat(16'd6, 1'b0, t);
    send_beat(16'd7, 1'b1, t);
    for (int w = 0; w < 50; w++) begin
      if (cyc >= t + 5) break;
      @(negedge clk);
    end
    check("no_out_before_rst", out_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); win_q.delete(); out_q.delete();
    idle(20);
    check("no_valid_after_rst", out_q.size(), 0);
    check("ready_after_mid_rst", s_ready, 1'b1);
    send_beat(16'd2, 1'b0, t);
    send_beat(16'd2, 1'b1, t);
    wait_outputs(2);
    if (out_q.size() >= 2) begin
      check("post_rst_data0", out_q[0].data, 32'h0000_8000);
      check("post_rst_last0", out_q[0].last, 1'b0);
      check("post_rst_data1", out_q[1].data, 32'h0000_8000);
      check("post_rst_last1", out_q[1].last, 1'b1);
    end
    check_vs_model();

    // Random vectors against the model
    for (int v = 0; v < 25; v++) begin
      n = $urandom_range(1, 20);
      mode = $urandom_range(0, 7);
      for (int i = 0; i < n; i++) begin
        if (mode == 0)      d = 16'h0;
        else if (mode == 1) d = 16'($urandom_range(0, 3));
        else                d = 16'($urandom_range(0, 65535));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send_beat(d, i == n - 1, t);
      end
      check_vs_model();
    end

    idle(10);
    check("extra_outputs", out_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
